// File: rtl/dma_sequencer.sv
// DMA sequencer: requests the control matrix, loads MAR or PC, then streams a
// burst of source words onto the write bus. Every output is registered.
module dma_sequencer #(
    parameter int width        = 16,
    parameter int len_width    = 8,
    parameter int appr_timeout = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [width-1:0]     base_addr,
    input  logic [len_width-1:0] len,
    input  logic [width-1:0]     data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 dma_appr,
    output logic                 cpu_dma_req,
    output logic                 cpu_rst,
    output logic [2:0]           we_out,
    output logic                 mar_incr,
    output logic [width-1:0]     bus_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int cnt_w = $clog2(appr_timeout + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(appr_timeout - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        REQ       = 4'd1,
        LDMAR     = 4'd2,
        LDPC      = 4'd3,
        WAIT_DATA = 4'd4,
        WRITE     = 4'd5,
        INCR      = 4'd6,
        RELEASE   = 4'd7,
        FIN       = 4'd8
    } state_t;

    state_t               state_r;
    state_t               nxt_s;
    logic [cnt_w-1:0]     cnt_r;
    logic [len_width-1:0] rem_r;
    logic [width-1:0]     base_r;
    logic                 pc_load_r;
    logic                 abort_r;
    logic                 idle_like_s;
    logic                 accept_s;
    logic                 zero_len_s;
    logic                 reserved_s;
    logic                 in_dma_s;
    logic                 abort_set_s;

    // Start decode, abort detection and next-state selection.
    always_comb begin
        idle_like_s = (state_r == IDLE) || (state_r == FIN);
        accept_s    = idle_like_s && start &&
                      ((mode == 2'b01) || ((mode == 2'b00) && (len != '0)));
        zero_len_s  = idle_like_s && start && (mode == 2'b00) && (len == '0);
        reserved_s  = idle_like_s && start && mode[1];
        in_dma_s    = state_r inside {LDMAR, LDPC, WAIT_DATA, WRITE, INCR};
        abort_set_s = (in_dma_s && !dma_appr) ||
                      ((state_r == REQ) && !dma_appr && (cnt_r >= cnt_last));
        nxt_s       = IDLE;
        case (state_r)
            IDLE, FIN: begin
                if (accept_s) nxt_s = REQ;
                else          nxt_s = IDLE;
            end
            REQ: begin
                if (dma_appr)                nxt_s = pc_load_r ? LDPC : LDMAR;
                else if (cnt_r >= cnt_last)  nxt_s = RELEASE;
                else                         nxt_s = REQ;
            end
            LDMAR: begin
                if (dma_appr) nxt_s = WAIT_DATA;
                else          nxt_s = RELEASE;
            end
            LDPC: nxt_s = RELEASE;
            WAIT_DATA: begin
                if (!dma_appr)       nxt_s = RELEASE;
                else if (data_valid) nxt_s = WRITE;
                else                 nxt_s = WAIT_DATA;
            end
            // rem_r still holds the count including the word being written
            WRITE: begin
                if (!dma_appr)                     nxt_s = RELEASE;
                else if (rem_r <= len_width'(1))   nxt_s = RELEASE;
                else                               nxt_s = INCR;
            end
            INCR: begin
                if (dma_appr) nxt_s = WAIT_DATA;
                else          nxt_s = RELEASE;
            end
            RELEASE: nxt_s = FIN;
            default: nxt_s = IDLE;
        endcase
    end

    // State, transfer context and outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rem_r       <= '0;
            base_r      <= '0;
            pc_load_r   <= 1'b0;
            abort_r     <= 1'b0;
            cpu_dma_req <= 1'b0;
            cpu_rst     <= 1'b0;
            busy        <= 1'b0;
            we_out      <= 3'b000;
            mar_incr    <= 1'b0;
            data_ready  <= 1'b0;
            bus_data    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r <= nxt_s;
            if (accept_s) begin
                pc_load_r <= mode[0];
                base_r    <= base_addr;
                rem_r     <= len;
                cnt_r     <= '0;
                abort_r   <= 1'b0;
            end else if ((state_r == REQ) && (cnt_r < cnt_last)) begin
                cnt_r <= cnt_r + cnt_w'(1);
            end else if ((state_r == WRITE) && (rem_r != '0)) begin
                rem_r <= rem_r - len_width'(1);
            end
            if (abort_set_s) begin
                abort_r <= 1'b1;
            end

            cpu_dma_req <= 1'b0;
            cpu_rst     <= 1'b0;
            busy        <= 1'b0;
            we_out      <= 3'b000;
            mar_incr    <= 1'b0;
            data_ready  <= 1'b0;
            bus_data    <= '0;
            done        <= zero_len_s;
            err         <= reserved_s;
            case (nxt_s)
                REQ: begin
                    cpu_dma_req <= 1'b1;
                    cpu_rst     <= 1'b1;
                    busy        <= 1'b1;
                end
                LDMAR, LDPC: begin
                    cpu_dma_req <= 1'b1;
                    cpu_rst     <= 1'b1;
                    busy        <= 1'b1;
                    we_out      <= (nxt_s == LDPC) ? 3'b100 : 3'b101;
                    bus_data    <= base_r;
                end
                WAIT_DATA: begin
                    cpu_dma_req <= 1'b1;
                    cpu_rst     <= 1'b1;
                    busy        <= 1'b1;
                    data_ready  <= 1'b1;
                end
                WRITE: begin
                    cpu_dma_req <= 1'b1;
                    cpu_rst     <= 1'b1;
                    busy        <= 1'b1;
                    we_out      <= 3'b011;
                    bus_data    <= data_in;
                end
                INCR: begin
                    cpu_dma_req <= 1'b1;
                    cpu_rst     <= 1'b1;
                    busy        <= 1'b1;
                    mar_incr    <= 1'b1;
                end
                // cpu_rst alone forces the control matrix back to a clean state
                RELEASE: begin
                    cpu_rst <= 1'b1;
                    busy    <= 1'b1;
                end
                FIN: begin
                    done <= !abort_r;
                    err  <= abort_r;
                end
                default: begin
                    cpu_dma_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_sequencer.sv
// Self-checking bench for dma_sequencer: directed scenarios plus random
// transfers compared cycle by cycle against a transaction-level trace model.
module tb_dma_sequencer;
    localparam int T = 16;
    localparam logic [25:0] DONE_BIT = 26'h0040000;
    localparam logic [25:0] ERR_BIT  = 26'h0020000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] base_addr;
    logic [7:0]  len;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        dma_appr;
    logic        cpu_dma_req;
    logic        cpu_rst;
    logic [2:0]  we_out;
    logic        mar_incr;
    logic [15:0] bus_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp   = 0;
    int n_err   = 0;
    int mar_cnt = 0;

    typedef enum int {K_IDLE, K_REQ, K_LDMAR, K_LDPC, K_WAIT, K_WRITE, K_INCR, K_REL, K_FIN} kind_t;

    always #5 clk = ~clk;

    dma_sequencer #(.width(16), .len_width(8), .appr_timeout(T)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .len(len), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .dma_appr(dma_appr), .cpu_dma_req(cpu_dma_req), .cpu_rst(cpu_rst),
        .we_out(we_out), .mar_incr(mar_incr), .bus_data(bus_data), .busy(busy),
        .done(done), .err(err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Packed view {req, rst, we, mar, busy, done, err, ready, bus}
    function automatic logic [25:0] obs();
        return {cpu_dma_req, cpu_rst, we_out, mar_incr, busy, done, err, data_ready, bus_data};
    endfunction

    function automatic logic [25:0] rec(input kind_t k, input logic [15:0] bus, input logic ab);
        logic req = 1'b0, crst = 1'b0, mi = 1'b0, by = 1'b0, dn = 1'b0, er = 1'b0, dr = 1'b0;
        logic [2:0]  we = 3'b000;
        logic [15:0] bd = 16'h0000;
        case (k)
            K_REQ:   begin req = 1'b1; crst = 1'b1; by = 1'b1; end
            K_LDMAR: begin req = 1'b1; crst = 1'b1; by = 1'b1; we = 3'b101; bd = bus; end
            K_LDPC:  begin req = 1'b1; crst = 1'b1; by = 1'b1; we = 3'b100; bd = bus; end
            K_WAIT:  begin req = 1'b1; crst = 1'b1; by = 1'b1; dr = 1'b1; end
            K_WRITE: begin req = 1'b1; crst = 1'b1; by = 1'b1; we = 3'b011; bd = bus; end
            K_INCR:  begin req = 1'b1; crst = 1'b1; by = 1'b1; mi = 1'b1; end
            K_REL:   begin crst = 1'b1; by = 1'b1; end
            K_FIN:   begin dn = !ab; er = ab; end
            default: begin dn = 1'b0; end
        endcase
        return {req, crst, we, mi, by, dn, er, dr, bd};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic st, input logic [1:0] md, input logic [15:0] ba, input logic [7:0] ln,
                        input logic [15:0] di, input logic dv, input logic ap,
                        input logic [25:0] want, input string tag);
        start = st; mode = md; base_addr = ba; len = ln;
        data_in = di; data_valid = dv; dma_appr = ap;
        @(posedge clk);
        #1;
        if (mar_incr) mar_cnt++;
        check_val(tag, {6'b0, obs()}, {6'b0, want});
    endtask

    // Junk start/mode/len while busy must be ignored, so they are randomised.
    task automatic busy_step(input logic [15:0] di, input logic dv, input logic ap,
                             input logic [25:0] want, input string tag);
        step(rbit(), 2'($urandom), 16'($urandom), 8'($urandom), di, dv, ap, want, tag);
    endtask

    task automatic run_xfer(input string tag, input logic [1:0] md, input logic [15:0] ba,
                            input logic [7:0] ln, input int appr_dly, input int stall,
                            input int abort_at, input logic [15:0] d0, input int rst_write);
        kind_t cur, nxt;
        int wr = 0, s = 0, pc = 0;
        logic ab = 1'b0, ap, dv;
        logic [15:0] w;
        if (md[1] || (md == 2'b00 && ln == 8'd0)) begin
            step(1'b1, md, ba, ln, 16'($urandom), rbit(), 1'b0,
                 rec(K_IDLE, 16'h0000, 1'b0) | (md[1] ? ERR_BIT : DONE_BIT), {tag, "/imm"});
            step(1'b0, 2'b00, 16'h0000, 8'd0, 16'($urandom), rbit(), 1'b0,
                 rec(K_IDLE, 16'h0000, 1'b0), {tag, "/idle"});
            return;
        end
        step(1'b1, md, ba, ln, 16'($urandom), rbit(), 1'b0, rec(K_REQ, 16'h0000, 1'b0), {tag, "/req"});
        cur = K_REQ;
        for (int j = 1; j <= T; j++) begin
            ap = (j >= appr_dly);
            if (ap)          nxt = md[0] ? K_LDPC : K_LDMAR;
            else if (j == T) begin nxt = K_REL; ab = 1'b1; end
            else             nxt = K_REQ;
            busy_step(16'($urandom), rbit(), ap, rec(nxt, ba, 1'b0), {tag, "/appr"});
            cur = nxt;
            if (nxt != K_REQ) break;
        end
        while (cur != K_REL) begin
            pc++;
            ap = !(abort_at != 0 && pc >= abort_at);
            dv = rbit();
            w  = 16'($urandom);
            if (!ap) begin
                nxt = K_REL;
                ab  = 1'b1;
            end else begin
                case (cur)
                    K_LDMAR, K_INCR: begin nxt = K_WAIT; s = 0; end
                    K_WAIT: begin
                        if (s < stall) begin
                            dv = 1'b0; s++; nxt = K_WAIT;
                        end else begin
                            dv = 1'b1; w = d0 + 16'(wr) * 16'h0011; nxt = K_WRITE; wr++;
                        end
                    end
                    K_WRITE: nxt = (wr < int'(ln)) ? K_INCR : K_REL;
                    default: nxt = K_REL;
                endcase
            end
            busy_step(w, dv, ap, rec(nxt, w, 1'b0), {tag, "/xfer"});
            cur = nxt;
            if (rst_write != 0 && nxt == K_WRITE && wr == rst_write) begin
                start = 1'b0;
                rst   = 1'b0;
                #1;
                check_val({tag, "/rst_async"}, {6'b0, obs()}, 32'h0);
                @(posedge clk);
                #1;
                check_val({tag, "/rst_hold"}, {6'b0, obs()}, 32'h0);
                rst = 1'b1;
                return;
            end
        end
        busy_step(16'($urandom), rbit(), rbit(), rec(K_FIN, 16'h0000, ab), {tag, "/fin"});
        step(1'b0, 2'b00, 16'h0000, 8'd0, 16'($urandom), rbit(), rbit(),
             rec(K_IDLE, 16'h0000, 1'b0), {tag, "/idle"});
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, md, ln, ab_at, rw;
        rst = 1'b0; start = 1'b0; mode = 2'b00; base_addr = 16'h0000; len = 8'd0;
        data_in = 16'h0000; data_valid = 1'b0; dma_appr = 1'b0;
        #1;
        check_val("reset_async", {6'b0, obs()}, 32'h0);
        @(posedge clk);
        #1;
        check_val("reset_hold", {6'b0, obs()}, 32'h0);
        rst = 1'b1;

        mar_cnt = 0;
        run_xfer("burst3", 2'b00, 16'h0040, 8'd3, 1, 0, 0, 16'h00A1, 0);
        check_val("burst3_mar_cnt", 32'(mar_cnt), 32'd2);
        run_xfer("pcload", 2'b01, 16'h1234, 8'd0, 1, 0, 0, 16'h0000, 0);
        run_xfer("timeout", 2'b00, 16'h0100, 8'd4, 100, 0, 0, 16'h0000, 0);
        run_xfer("stall", 2'b00, 16'h0200, 8'd2, 1, 5, 0, 16'h5A00, 0);
        run_xfer("zero_len", 2'b00, 16'h0300, 8'd0, 1, 0, 0, 16'h0000, 0);
        run_xfer("mode11", 2'b11, 16'h0300, 8'd5, 1, 0, 0, 16'h0000, 0);
        run_xfer("rst_mid", 2'b00, 16'h0400, 8'd4, 1, 0, 0, 16'h1000, 2);
        run_xfer("post_rst", 2'b00, 16'h0500, 8'd2, 1, 0, 0, 16'h2000, 0);
        run_xfer("appr_last", 2'b00, 16'h0600, 8'd1, T, 0, 0, 16'h3000, 0);
        run_xfer("abort_pc", 2'b01, 16'h0700, 8'd0, 2, 0, 1, 16'h0000, 0);
        run_xfer("abort_last_wr", 2'b00, 16'h0800, 8'd2, 1, 0, 6, 16'h4000, 0);
        run_xfer("len255", 2'b00, 16'h0900, 8'd255, 3, 0, 0, 16'h0001, 0);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            md = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            ln = $urandom_range(0, 6);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * ln + 3) : 0;
            rw = ($urandom_range(0, 9) == 0 && ln > 0) ? $urandom_range(1, ln) : 0;
            run_xfer("rand", 2'(md), 16'($urandom), 8'(ln), $urandom_range(1, T + 2),
                     $urandom_range(0, 3), ab_at, 16'($urandom), rw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
